// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU with iterative multiply/divide.
//   alu_op_t    : 3-bit operation code carried on the op port
//   OP_*        : operation encodings
//   alu_state_t : control FSM states of seq_alu_muldiv
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_AND  = 3'b000;
  localparam alu_op_t OP_OR   = 3'b001;
  localparam alu_op_t OP_ADD  = 3'b010;
  localparam alu_op_t OP_SUB  = 3'b011;
  localparam alu_op_t OP_SLT  = 3'b100;
  localparam alu_op_t OP_MUL  = 3'b101;
  localparam alu_op_t OP_DIVU = 3'b110;
  localparam alu_op_t OP_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add) and, when SEQ_ALU_DIV_EN is
// defined, restoring divide. One result bit per cycle, WIDTH iterations.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load operands and begin iterating (ignored fields when busy)
//   mode       : operation (OP_MUL, OP_DIVU, OP_REMU)
//   a, b       : multiplicand/dividend, multiplier/divisor
//   done       : final iteration complete, result valid this cycle
//   result     : low product word, quotient or remainder
//   hi_nz      : high product word is nonzero (multiply overflow)
// Macro: SEQ_ALU_DIV_EN enables the divider datapath.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_t          mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     mul_sum;

`ifdef SEQ_ALU_DIV_EN
  logic               div_mode_q;
  logic               rem_sel_q;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
`else
  logic               unused_mode;
  assign unused_mode = ^mode;
`endif

  assign done  = busy_q && (cnt_q == '0);
  assign hi_nz = |acc_q[2*WIDTH-1:WIDTH];

`ifdef SEQ_ALU_DIV_EN
  assign result = rem_sel_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
`else
  assign result = acc_q[WIDTH-1:0];
`endif

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    // A zero divisor always "fits": quotient fills with ones and the
    // dividend bits shift unchanged into the remainder.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = WIDTH'(div_shift - {1'b0, opb_q});
    if (div_mode_q) begin
      if (div_ge) acc_next = {div_rem, acc_q[WIDTH-2:0], 1'b1};
      else        acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_mode_q <= 1'b0;
      rem_sel_q  <= 1'b0;
`endif
    end else if (start) begin
      acc_q      <= {{WIDTH{1'b0}}, a};
      opb_q      <= b;
      cnt_q      <= CNT_W'(WIDTH);
      busy_q     <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
      div_mode_q <= (mode == OP_DIVU) || (mode == OP_REMU);
      rem_sel_q  <= (mode == OP_REMU);
`endif
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu_muldiv.sv
// Registered, valid/ready handshaked ALU: AND/OR/ADD/SUB/SLT in one cycle,
// MUL/DIVU/REMU iterated over WIDTH cycles in seq_muldiv_core.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : request handshake (one request in flight)
//   in1, in2, op        : operands and operation
//   out_valid, out_ready: result handshake, outputs held until accepted
//   result, overflow, zero : registered result and flags
// Macro: SEQ_ALU_DIV_EN adds the divider; without it DIVU/REMU complete in
// one cycle with result=0, overflow=1.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// MUL   | shift-add multiply iterating
// DIV   | restoring divide iterating
// DONE  | out_valid=1, holding result until out_ready
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_op_t          op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  alu_state_t       state_q, state_d;
  logic             start;
  logic             core_done;
  logic [WIDTH-1:0] core_result;
  logic             core_hi_nz;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
`ifdef SEQ_ALU_DIV_EN
  logic             div_zero_q;
`endif

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (op),
    .a      (in1),
    .b      (in2),
    .done   (core_done),
    .result (core_result),
    .hi_nz  (core_hi_nz)
  );

  // Single-cycle results are evaluated on the accept cycle and registered
  // straight into the output, which gives the one-cycle latency.
  always_comb begin
    sum     = in1 + in2;
    diff    = in1 - in2;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
`ifndef SEQ_ALU_DIV_EN
      OP_DIVU, OP_REMU: alu_ovf = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d = MUL;
            start   = 1'b1;
          end
`ifdef SEQ_ALU_DIV_EN
          else if ((op == OP_DIVU) || (op == OP_REMU)) begin
            state_d = DIV;
            start   = 1'b1;
          end
`endif
          else begin
            state_d = DONE;
          end
        end
      end
      MUL, DIV: if (core_done) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result     <= '0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_zero_q <= 1'b0;
`endif
    end else if ((state_q == IDLE) && in_valid) begin
      if (!start) begin
        result   <= alu_res;
        overflow <= alu_ovf;
        zero     <= (alu_res == '0);
      end
`ifdef SEQ_ALU_DIV_EN
      div_zero_q <= (in2 == '0);
`endif
    end else if (((state_q == MUL) || (state_q == DIV)) && core_done) begin
      result <= core_result;
      zero   <= (core_result == '0);
`ifdef SEQ_ALU_DIV_EN
      overflow <= (state_q == DIV) ? div_zero_q : core_hi_nz;
`else
      overflow <= core_hi_nz;
`endif
    end
  end

endmodule

// File: doc/seq_alu_muldiv.md
Name: seq_alu_muldiv

Overview:
- Registered, handshaked N-bit ALU, successor to the combinational N-bit ALU.
- Adds iterative unsigned multiply and divide/remainder on top of AND/OR/ADD/SUB/SLT.
- Uses valid/ready on both input and output so it can sit between pipeline stages of the datapath playground.
- Single-cycle ops complete in 1 cycle; MUL/DIV take WIDTH iterations.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in1  input  WIDTH  first operand.
- in2  input  WIDTH  second operand.
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL (low word), 110 DIVU (quotient), 111 REMU (remainder).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- overflow  output  1  registered overflow/error flag.
- zero  output  1  registered result==0.

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, zero=0, counter=0.
- Reset mid-operation aborts the iteration and discards the pending result. No output is produced for the aborted request.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready and latch in1, in2, op.
    - ops 000-100 → DONE next cycle, with result computed combinationally from the latched operands.
    - MUL → MUL state; DIVU/REMU → DIV state.
  - MUL: shift-add, one partial-product bit per cycle. After exactly WIDTH cycles → DONE.
  - DIV: restoring division, one quotient bit per cycle. After exactly WIDTH cycles → DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready. On out_valid&&out_ready → IDLE.
- in_ready=0 in MUL, DIV and DONE; only one request is in flight. There is no same-cycle DONE→accept bypass: the next accept is earliest one cycle after the output handshake.
- Latency (accept edge to out_valid high): 1 cycle for ops 000-100; WIDTH+1 cycles for MUL/DIVU/REMU.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH. overflow = signed overflow (operands same sign, result sign differs; for SUB compare against ~in2).
  - SLT: result = {WIDTH-1 zeros, (signed in1 < signed in2)}, correct even when in1-in2 overflows. overflow=0.
  - AND/OR: overflow=0.
  - MUL: result = low WIDTH bits of the unsigned product. overflow=1 iff the high WIDTH bits are nonzero.
  - DIVU/REMU by zero: quotient = all ones, remainder = in1, overflow=1, and it still takes WIDTH+1 cycles. Otherwise overflow=0.
- zero is computed from the final registered result in every op.
- in_valid while busy is ignored; the requester must hold it. out_ready while out_valid=0 has no effect.

Optional Feature:
- SEQ_ALU_DIV_EN defined: DIV state and restoring divider present; DIVU/REMU behave as above.
- Not defined: no divider logic. DIVU/REMU are treated as 1-cycle ops with result=0 and overflow=1 (illegal-op indication). The MUL path is unaffected.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants (OP_AND..OP_REMU), 3-bit typedef alu_op_t.
  - state typedef alu_state_t {IDLE, MUL, DIV, DONE}.
- One sub-module: seq_muldiv_core, the iterative shift-add/restoring datapath. It has start, mode, operands, done, result and high-word-nonzero outputs; the top holds the FSM and handshake.

Test Plan:
- Reset mid-MUL: WIDTH=8, MUL 3*5, assert rst_n=0 on iteration 4 → next cycle in_ready=1, out_valid=0, result=0; no stale output after release.
- ADD overflow: WIDTH=8, ADD 0x7F+0x01 → out_valid 1 cycle after accept, result=0x80, overflow=1, zero=0. Then SUB 0x05-0x05 → result=0, zero=1, overflow=0.
- SLT signed: WIDTH=8, SLT 0x80 vs 0x7F → result=0x01, overflow=0. Then SLT 0x7F vs 0x80 → result=0x00.
- MUL timing and overflow: WIDTH=8, MUL 0x10*0x10 → out_valid exactly 9 cycles after accept, result=0x00, overflow=1, zero=1. Then MUL 12*10 → 0x78, overflow=0.
- Divide (DIV_EN): WIDTH=8, DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → 0xFF, overflow=1; REMU 9/0 → 9. Without the macro, DIVU returns 0 with overflow=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after DONE → result, flags and out_valid stable; in_ready=0; in_valid pulses ignored. Release → accept occurs the cycle after the handshake.
